// File: rtl/xpmwrap_pkg.sv
// Shared types and helpers for the xpmwrap_sdpram read-side engine.
package xpmwrap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/xpmwrap_sdpram_reader_if.sv
// Command, RAM port-B and output-stream signals of the sdpram reader.
interface xpmwrap_sdpram_reader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;

  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  regceb;
  logic                  rstb;
  logic [DATA_WIDTH-1:0] doutb;

  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (
    input  start, start_addr, length, doutb, m_tready,
    output busy, done, enb, addrb, regceb, rstb, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output start, start_addr, length, doutb, m_tready,
    input  busy, done, enb, addrb, regceb, rstb, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/xpmwrap_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is read straight from storage flops.
module xpmwrap_sync_fifo
  import xpmwrap_pkg::*;
#(
  parameter int DATA_WIDTH = 33,
  parameter int FIFO_DEPTH = 4,
  localparam int PW = (FIFO_DEPTH > 1) ? clog2(FIFO_DEPTH) : 1,
  localparam int CW = clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
endmodule

// File: rtl/xpmwrap_sdpram_reader.sv
// Burst reader for xpmwrap_sdpram port B: issues credit-limited sequential reads
// and streams the returned words out as a valid/ready master with last marking.
module xpmwrap_sdpram_reader
  import xpmwrap_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input logic                     clk,
  input logic                     rst_n,
  xpmwrap_sdpram_reader_if.master bus
);
  localparam int IW = clog2(READ_LATENCY + 1);
  localparam int CW = clog2(FIFO_DEPTH + 1);
  localparam int SW = clog2(FIFO_DEPTH + READ_LATENCY + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_R = 1;

  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH:0]     remaining;
  logic [READ_LATENCY-1:0] tok_valid;
  logic [READ_LATENCY-1:0] tok_last;
  logic [IW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [DATA_WIDTH:0]     fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    issue;
  logic                    credit_ok;
  logic                    drain_done;
  logic                    done_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + IW'(tok_valid[i]);
  end

  // Every issued read owns a FIFO slot from issue until hand-off, so pushes never overflow.
  assign credit_ok  = !fifo_full && ((SW'(inflight) + SW'(fifo_count)) < SW'(FIFO_DEPTH));
  assign issue      = (state == S_RUN) && (remaining != '0) && credit_ok;
  assign push       = tok_valid[READ_LATENCY-1];
  assign pop        = !fifo_empty && bus.m_tready;
  assign drain_done = (inflight == '0) && (fifo_count == CW'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              addr      <= bus.start_addr;
              remaining <= bus.length;
              state     <= S_RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            addr      <= addr + ONE_A;
            remaining <= remaining - ONE_R;
            if (remaining == ONE_R) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Token pipeline mirrors the RAM read latency; the oldest token marks doutb valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_valid <= '0;
      tok_last  <= '0;
    end else begin
      tok_valid[0] <= issue;
      tok_last[0]  <= issue && (remaining == ONE_R);
      for (int i = 1; i < READ_LATENCY; i++) begin
        tok_valid[i] <= tok_valid[i-1];
        tok_last[i]  <= tok_last[i-1];
      end
    end
  end

  xpmwrap_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH + 1),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  ({tok_last[READ_LATENCY-1], bus.doutb}),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.enb      = issue;
  assign bus.addrb    = addr;
  assign bus.regceb   = tok_valid[0];
  assign bus.rstb     = 1'b0;
  assign bus.m_tdata  = fifo_dout[DATA_WIDTH-1:0];
  assign bus.m_tvalid = !fifo_empty;
  assign bus.m_tlast  = !fifo_empty && fifo_dout[DATA_WIDTH];
endmodule

// File: tb/tb_xpmwrap_sdpram_reader.sv
// Scoreboard bench for xpmwrap_sdpram_reader with a behavioural 2-cycle RAM model.
module tb_xpmwrap_sdpram_reader;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int WORDS = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  xpmwrap_sdpram_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rd_if ();

  xpmwrap_sdpram_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (rd_if)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] ram_stage;

  // RAM port B: enable registers the array word, regceb moves it to doutb.
  always @(posedge clk) begin
    if (rd_if.enb) ram_stage <= mem[rd_if.addrb];
    if (rd_if.rstb) rd_if.doutb <= '0;
    else if (rd_if.regceb) rd_if.doutb <= ram_stage;
  end

  int    tests = 0, failures = 0;
  int    cyc = 0, cmd_cyc = 0, first_lat = -1;
  int    issued = 0, handed = 0, lasts = 0, done_count = 0, expected_done = 0, max_out = 0;
  bit    first_pending = 0, ready_random = 0, stall_prev = 0;
  logic  [DW-1:0] stall_data;
  beat_t exp_q[$];
  int    addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ready_random) rd_if.m_tready = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: a command reads mem[(addr+i) mod 2^AW] for i < len, last flag on the final word.
  task automatic applyStimulus(input int addr, input int len);
    rd_if.start      = 1'b1;
    rd_if.start_addr = AW'(addr);
    rd_if.length     = (AW + 1)'(len);
    cmd_cyc          = cyc;
    first_pending    = 1'b1;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{data: mem[(addr + i) % WORDS], last: (i == len - 1)});
      addr_q.push_back((addr + i) % WORDS);
    end
    expected_done++;
    @(posedge clk); #1;
    rd_if.start = 1'b0;
  endtask

  task automatic pulseIgnoredStart(input int addr, input int len);
    rd_if.start      = 1'b1;
    rd_if.start_addr = AW'(addr);
    rd_if.length     = (AW + 1)'(len);
    @(posedge clk); #1;
    rd_if.start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rd_if.done) return;
      @(posedge clk); #1;
    end
    tests++;
    failures++;
    $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", budget);
  endtask

  // Monitor: pops the scoreboard on every handshake and tracks issue/hand-off totals.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        checkOutput("hold_valid", rd_if.m_tvalid, 1);
        checkOutput("hold_data", rd_if.m_tdata, stall_data);
      end
      stall_prev = rd_if.m_tvalid && !rd_if.m_tready;
      stall_data = rd_if.m_tdata;
      if (rd_if.enb) begin
        if (addr_q.size() == 0) checkOutput("enb_expected", rd_if.enb, 0);
        else checkOutput("addrb", rd_if.addrb, addr_q.pop_front());
        issued++;
        if (issued - handed > max_out) max_out = issued - handed;
      end
      if (first_pending && rd_if.m_tvalid) begin
        first_lat     = cyc - cmd_cyc;
        first_pending = 1'b0;
      end
      if (rd_if.m_tvalid && rd_if.m_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("beat_expected", rd_if.m_tvalid, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          checkOutput("m_tdata", rd_if.m_tdata, e.data);
          checkOutput("m_tlast", rd_if.m_tlast, e.last);
        end
        handed++;
        if (rd_if.m_tlast) lasts++;
      end
      if (rd_if.done) done_count++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int base, lbase, ibase;
    rd_if.start      = 1'b0;
    rd_if.start_addr = '0;
    rd_if.length     = '0;
    rd_if.m_tready   = 1'b1;
    for (int i = 0; i < WORDS; i++) mem[i] = DW'(i + 'h100);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", rd_if.busy, 0);
    checkOutput("reset_done", rd_if.done, 0);
    checkOutput("reset_enb", rd_if.enb, 0);
    checkOutput("reset_addrb", rd_if.addrb, 0);
    checkOutput("reset_regceb", rd_if.regceb, 0);
    checkOutput("reset_rstb", rd_if.rstb, 0);
    checkOutput("reset_tvalid", rd_if.m_tvalid, 0);
    checkOutput("reset_tlast", rd_if.m_tlast, 0);
    checkOutput("reset_tdata", rd_if.m_tdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic burst");
    applyStimulus(0, 4);
    checkOutput("basic_busy", rd_if.busy, 1);
    waitDone(50);
    checkOutput("basic_first_valid_cycle", first_lat, 4);
    checkOutput("basic_done_cycle", cyc - cmd_cyc, 8);
    checkOutput("basic_busy_at_done", rd_if.busy, 0);

    $display("[TB] wrap-around, started in the done cycle");
    applyStimulus(62, 4);
    waitDone(50);
    checkOutput("wrap_first_valid_cycle", first_lat, 4);
    checkOutput("wrap_done_cycle", cyc - cmd_cyc, 8);

    $display("[TB] backpressure");
    ibase   = issued;
    base    = handed;
    max_out = 0;
    applyStimulus(5, 16);
    repeat (2) @(posedge clk);
    #1;
    rd_if.m_tready = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("stall_issue_count", issued - ibase, DEPTH);
    @(posedge clk); #1;
    rd_if.m_tready = 1'b1;
    waitDone(200);
    checkOutput("backpressure_beats", handed - base, 16);
    checkOutput("max_outstanding_within_depth", (max_out <= DEPTH), 1);

    $display("[TB] zero length and ignored start");
    ibase = issued;
    base  = handed;
    applyStimulus(9, 0);
    waitDone(5);
    checkOutput("zero_done_cycle", cyc - cmd_cyc, 1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("zero_no_enb", issued - ibase, 0);
    checkOutput("zero_no_beat", handed - base, 0);
    base = handed;
    applyStimulus(30, 8);
    repeat (2) @(posedge clk);
    #1;
    pulseIgnoredStart(40, 5);
    waitDone(100);
    checkOutput("busy_start_beats", handed - base, 8);

    $display("[TB] full memory with random ready");
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    base  = handed;
    lbase = lasts;
    ready_random = 1'b1;
    applyStimulus($urandom_range(0, WORDS - 1), WORDS);
    waitDone(1000);
    checkOutput("full_mem_beats", handed - base, WORDS);
    checkOutput("full_mem_last_count", lasts - lbase, 1);

    $display("[TB] random commands");
    for (int k = 0; k < 5; k++) begin
      applyStimulus($urandom_range(0, WORDS - 1), $urandom_range(1, WORDS));
      waitDone(1000);
    end
    ready_random   = 1'b0;
    rd_if.m_tready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset mid-burst");
    base = handed;
    applyStimulus(20, 16);
    for (int i = 0; i < 200 && (handed - base) < 5; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("reset_wait_beats", ((handed - base) >= 5), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", rd_if.busy, 0);
    checkOutput("midrst_enb", rd_if.enb, 0);
    checkOutput("midrst_addrb", rd_if.addrb, 0);
    checkOutput("midrst_regceb", rd_if.regceb, 0);
    checkOutput("midrst_tvalid", rd_if.m_tvalid, 0);
    checkOutput("midrst_tlast", rd_if.m_tlast, 0);
    checkOutput("midrst_tdata", rd_if.m_tdata, 0);
    exp_q.delete();
    addr_q.delete();
    expected_done--;
    issued = 0;
    handed = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(7, 2);
    waitDone(50);
    checkOutput("post_reset_beats", handed, 2);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("addr_queue_empty", addr_q.size(), 0);
    checkOutput("done_count", done_count, expected_done);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
